// File: rtl/case_7_mul_arbiter.sv
// case_7_mul_arbiter: round-robin scheduler sharing one signed multiplier
// among NUM_REQ requesters; each result is tagged with the owner's index.
// Ports:
//   ap_clk, ap_rst            clock, asynchronous active-high reset
//   req_valid, req_ready      per-requester operand handshake
//   req_din0, req_din1        packed operands, requester i at [i*W +: W]
//   rsp_valid, rsp_ready      result handshake
//   rsp_dout, rsp_id          truncated signed product and owner index
//   txn_count                 completed response handshakes (wraps at 16 bits)
module case_7_mul_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DIN0_WIDTH = 11,
    parameter int DIN1_WIDTH = 6,
    parameter int DOUT_WIDTH = 11,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0,
    input  logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DOUT_WIDTH-1:0]         rsp_dout,
    output logic [ID_W-1:0]               rsp_id,
    output logic [15:0]                   txn_count
);

    localparam int P_W = DIN0_WIDTH + DIN1_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                       state;
    logic [ID_W-1:0]              rr_ptr;
    logic [ID_W-1:0]              grant;
    logic                         grant_found;
    logic [ID_W:0]                cand;
    logic                         accept_open;
    logic                         accept;
    logic signed [DIN0_WIDTH-1:0] sel0;
    logic signed [DIN1_WIDTH-1:0] sel1;
    logic signed [DIN0_WIDTH-1:0] op0;
    logic signed [DIN1_WIDTH-1:0] op1;
    logic [ID_W-1:0]              op_id;
    logic signed [P_W-1:0]        product;
    logic [15:0]                  txn_cnt_q;

    // First valid requester at or above rr_ptr, wrapping past NUM_REQ-1.
    // cand is one bit wider so the sum cannot overflow before the wrap.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant       = cand[ID_W-1:0];
                grant_found = 1'b1;
            end
        end
    end

    // In HOLD the slot frees up in the same cycle the result drains,
    // which is what gives back-to-back results every two cycles.
    assign accept_open = (state == IDLE) ||
                         ((state == HOLD) && rsp_ready);

    // Gating with ap_rst keeps every ready low while reset is held.
    assign accept = accept_open && grant_found && !ap_rst;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        sel0 = '0;
        sel1 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                sel0 = req_din0[i*DIN0_WIDTH +: DIN0_WIDTH];
                sel1 = req_din1[i*DIN1_WIDTH +: DIN1_WIDTH];
            end
        end
    end

    // Full-width signed product; the response keeps only the low bits.
    assign product = P_W'(op0) * P_W'(op1);

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            op0       <= '0;
            op1       <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_dout  <= '0;
            rsp_id    <= '0;
            txn_cnt_q <= '0;
        end else begin
            if (accept) begin
                op0   <= sel0;
                op1   <= sel1;
                op_id <= grant;
                if (grant == ID_W'(NUM_REQ - 1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= grant + ID_W'(1);
                end
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    rsp_dout  <= product[DOUT_WIDTH-1:0];
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (rsp_ready) begin
                        txn_cnt_q <= txn_cnt_q + 16'd1;
                        rsp_valid <= 1'b0;
                        state     <= accept ? CALC : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign txn_count = txn_cnt_q;

endmodule

// File: tb/tb_case_7_mul_arbiter.sv
// Testbench for case_7_mul_arbiter: table-driven vectors plus
// hand-written fairness, backpressure, reset and wrap sequences.
module tb_case_7_mul_arbiter;

    localparam int N  = 4;
    localparam int W0 = 11;
    localparam int W1 = 6;
    localparam int WO = 11;
    localparam int IW = 2;
    localparam int QD = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W0-1:0] req_din0;
    logic [N*W1-1:0] req_din1;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [WO-1:0]   rsp_dout;
    logic [IW-1:0]   rsp_id;
    logic [15:0]     txn_count;

    case_7_mul_arbiter #(
        .NUM_REQ   (N),
        .DIN0_WIDTH(W0),
        .DIN1_WIDTH(W1),
        .DOUT_WIDTH(WO)
    ) dut (
        .ap_clk   (clk),
        .ap_rst   (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_din0 (req_din0),
        .req_din1 (req_din1),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dout (rsp_dout),
        .rsp_id   (rsp_id),
        .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int a;
        int b;
        int exp;
    } vec_t;

    typedef struct {
        int id;
        int dout;
        int cyc;
    } sb_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    sb_t         sbq[$];
    int          qa[N][QD];
    int          qb[N][QD];
    int          qe[N][QD];
    int          head[N];
    int          tail[N];
    bit          acc[N];
    bit          fresh;
    int          vstart;
    logic [15:0] model_txn;
    int          ord[8];
    int          ord_idx;
    bit          ord_on;
    bit          thr_on;
    int          last_acc;
    vec_t        vt[8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference product: low 11 bits of the full product, read as signed.
    function automatic int mdl(input int a, input int b);
        int          p;
        logic [10:0] t;
        p = a * b;
        t = p[10:0];
        return int'($signed(t));
    endfunction

    task automatic enq(input int id, input int a, input int b, input int e);
        qa[id][tail[id]] = a;
        qb[id][tail[id]] = b;
        qe[id][tail[id]] = e;
        tail[id]++;
    endtask

    task automatic flush();
        sbq.delete();
        for (int i = 0; i < N; i++) begin
            head[i] = tail[i];
            acc[i]  = 1'b0;
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        bit busy;
        n = 0;
        do begin
            @(negedge clk);
            busy = (sbq.size() != 0) || rsp_valid;
            for (int i = 0; i < N; i++) begin
                if (head[i] < tail[i]) busy = 1'b1;
            end
            n++;
        end while (busy && n < 200);
        if (busy) chk({name, "_timeout"}, 1, 0);
    endtask

    // Driver: each requester presents the head of its own operand queue.
    initial begin
        req_valid = '0;
        req_din0  = '0;
        req_din1  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    head[i]++;
                    acc[i] = 1'b0;
                end
                if (head[i] < tail[i]) begin
                    req_valid[i] = 1'b1;
                    req_din0[i*W0 +: W0] = W0'(qa[i][head[i]]);
                    req_din1[i*W1 +: W1] = W1'(qb[i][head[i]]);
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: accepts push expectations, responses pop and compare.
    always @(negedge clk) begin
        sb_t e;
        if (rst) begin
            fresh = 1'b1;
        end else begin
            if (rsp_valid && fresh) begin
                vstart = cyc;
                fresh  = 1'b0;
            end
            if (req_ready != '0) begin
                chk("ready_legal",
                    int'(($countones(req_ready) == 1) &&
                         ((req_ready & ~req_valid) == '0)), 1);
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id   = i;
                    e.dout = qe[i][head[i]];
                    e.cyc  = cyc;
                    sbq.push_back(e);
                    acc[i] = 1'b1;
                    if (ord_on) begin
                        if (ord_idx < 8) chk("grant_order", i, ord[ord_idx]);
                        else chk("grant_extra", 1, 0);
                        if (thr_on && ord_idx > 0)
                            chk("throughput", cyc - last_acc, 2);
                        ord_idx++;
                        last_acc = cyc;
                    end
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (sbq.size() == 0) begin
                    chk("spurious_rsp", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_dout", int'($signed(rsp_dout)), e.dout);
                    chk("rsp_id", int'(rsp_id), e.id);
                    chk("latency", vstart - e.cyc, 2);
                end
                chk("txn_count", int'(txn_count), int'(model_txn));
                model_txn = model_txn + 16'd1;
                fresh = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
            acc[i]  = 1'b0;
        end
        rsp_ready = 1'b1;
        fresh     = 1'b1;
        vstart    = 0;
        model_txn = '0;
        ord_on    = 1'b0;
        thr_on    = 1'b0;
        ord_idx   = 0;
        last_acc  = 0;

        vt[0] = '{2, 100, 5, 500};
        vt[1] = '{1, -300, -7, 52};
        vt[2] = '{0, -1024, -32, 0};
        vt[3] = '{3, 7, -3, -21};
        vt[4] = '{2, 1023, 31, 993};
        vt[5] = '{1, -1024, 1, -1024};
        vt[6] = '{0, 200, 20, -96};
        vt[7] = '{3, -1, -1, 1};

        // Reset state, with a request already pending.
        enq(vt[0].id, vt[0].a, vt[0].b, vt[0].exp);
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_dout", int'(rsp_dout), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_txn", int'(txn_count), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int k = 0; k < 8; k++) begin
            if (k > 0) enq(vt[k].id, vt[k].a, vt[k].b, vt[k].exp);
            wait_idle("vec");
            if (k == 0) chk("txn_after_first", int'(txn_count), 1);
        end

        // Fairness with all requesters continuously valid.
        ord = '{0, 1, 2, 3, 0, 1, 2, 3};
        ord_idx = 0;
        ord_on  = 1'b1;
        thr_on  = 1'b1;
        for (int r = 0; r < N; r++) begin
            enq(r, 10*r + 3, r - 4, mdl(10*r + 3, r - 4));
            enq(r, -50*r - 1, 7 + r, mdl(-50*r - 1, 7 + r));
        end
        wait_idle("fair");
        ord_on = 1'b0;
        thr_on = 1'b0;
        chk("fair_grants", ord_idx, 8);

        // Backpressure in HOLD, then drain and grant in one cycle.
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        enq(1, 50, -3, -150);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        chk("bp_valid_seen", int'(rsp_valid), 1);
        enq(2, 9, 9, 81);
        repeat (5) begin
            @(negedge clk);
            chk("bp_dout", int'($signed(rsp_dout)), -150);
            chk("bp_id", int'(rsp_id), 1);
            chk("bp_ready", int'(req_ready), 0);
            chk("bp_txn", int'(txn_count), int'(model_txn));
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_grant", int'(req_ready), 4);
        chk("bp_release_valid", int'(rsp_valid), 1);
        wait_idle("bp");

        // Reset while CALC: operand is dropped, pointer and count clear.
        enq(2, 77, -2, mdl(77, -2));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[2] && n < 20);
        chk("rst_mid_accept", int'(req_ready[2]), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_valid", int'(rsp_valid), 0);
        chk("rst_mid_dout", int'(rsp_dout), 0);
        chk("rst_mid_ready", int'(req_ready), 0);
        chk("rst_mid_txn", int'(txn_count), 0);
        flush();
        model_txn = '0;
        enq(3, 11, 3, mdl(11, 3));
        enq(1, -13, 5, mdl(-13, 5));
        ord[0]  = 1;
        ord[1]  = 3;
        ord_idx = 0;
        ord_on  = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_first_grant", int'(req_ready), 2);
        chk("rst_no_rsp", int'(rsp_valid), 0);
        wait_idle("rst");
        ord_on = 1'b0;
        chk("rst_grants", ord_idx, 2);

        // Counter wrap: preload near the top, then complete two more.
        @(posedge clk);
        #1;
        dut.txn_cnt_q = 16'hFFFE;
        model_txn     = 16'hFFFE;
        enq(0, 3, 4, 12);
        enq(1, -3, 4, -12);
        wait_idle("wrap");
        chk("txn_wrap", int'(txn_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
